// File: rtl/alpha_trim_pkg.sv
// Shared state encoding and sizing for the alpha-trimmed mean controller.
package alpha_trim_pkg;

   localparam int DN_DEF = 25;
   localparam int DW_DEF = 8;

   typedef enum logic [4:0] {
      ST_IDLE   = 5'b00001,
      ST_LAUNCH = 5'b00010,
      ST_WAIT   = 5'b00100,
      ST_ACCUM  = 5'b01000,
      ST_HOLD   = 5'b10000
   } state_t;

   // Sum of dn pixels of dw bits can never exceed this width.
   function automatic int sum_width(input int dw, input int dn);
      return dw + $clog2(dn);
   endfunction

endpackage

// File: rtl/alpha_trim_ctrl.sv
// Alpha-trimmed mean controller: latches a window, launches an external sorter,
// then sums the pixels whose sorted rank lies inside [trim, DN-1-trim].
module alpha_trim_ctrl
   import alpha_trim_pkg::*;
#(
   parameter int DN          = DN_DEF,
   parameter int DW          = DW_DEF,
   parameter int DW_sequence = $clog2(DN),
   parameter int TIMEOUT     = 15
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          win_valid,
   output logic                          win_ready,
   input  logic [DW*DN-1:0]              win_data,
   input  logic [DW_sequence-1:0]        trim,
   output logic                          sort_sig,
   output logic [DW*DN-1:0]              sort_data,
   input  logic                          sort_finish,
   input  logic [DW_sequence*DN-1:0]     sequence_sorted,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [sum_width(DW, DN)-1:0]  out_sum,
   output logic [DW_sequence:0]          out_cnt,
   output logic                          out_err
);

   localparam int SW  = sum_width(DW, DN);
   localparam int WCW = $clog2(TIMEOUT + 1);
   localparam logic [DW_sequence:0]   DN_X      = (DW_sequence + 1)'(DN);
   localparam logic [DW_sequence-1:0] RANK_MAX  = DW_sequence'(DN - 1);
   localparam logic [DW_sequence-1:0] TRIM_MAX  = DW_sequence'((DN - 1) / 2);
   localparam logic [WCW-1:0]         WAIT_LAST = WCW'(TIMEOUT - 1);

   state_t state, state_nxt;
   logic   alive;

   logic [DN-1:0][DW-1:0]          pix_q;
   logic [DN-1:0][DW_sequence-1:0] seq_q;
   logic [DW_sequence-1:0]         trim_q, trim_eff, rank, rank_last, idx;
   logic [WCW-1:0]                 wait_cnt;
   logic [SW-1:0]                  acc;
   logic [DW_sequence:0]           cnt;
   logic                           err, accept, idx_ok;
   logic [DW-1:0]                  pix_sel;

   assign accept    = win_valid && win_ready;
   assign trim_eff  = (({1'b0, trim} << 1) < DN_X) ? trim : TRIM_MAX;
   assign rank_last = RANK_MAX - trim_q;
   assign idx       = seq_q[rank];
   // A sorter index outside the window contributes nothing.
   assign idx_ok    = {1'b0, idx} < DN_X;
   assign pix_sel   = idx_ok ? pix_q[idx] : '0;

   assign sort_data = pix_q;
   assign out_sum   = acc;
   assign out_cnt   = cnt;
   assign out_err   = err;

   // alive keeps win_ready low while reset is held and for the release cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         alive <= 1'b0;
      end else begin
         state <= state_nxt;
         alive <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      win_ready = 1'b0;
      sort_sig  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            win_ready = alive;
            if (win_valid && alive) state_nxt = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            sort_sig  = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (sort_finish)                state_nxt = ST_ACCUM;
            else if (wait_cnt == WAIT_LAST) state_nxt = ST_HOLD;
         end
         ST_ACCUM: begin
            if (rank == rank_last) state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_q    <= '0;
         seq_q    <= '0;
         trim_q   <= '0;
         rank     <= '0;
         wait_cnt <= '0;
         acc      <= '0;
         cnt      <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  pix_q    <= win_data;
                  trim_q   <= trim_eff;
                  wait_cnt <= '0;
                  acc      <= '0;
                  cnt      <= '0;
                  err      <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (sort_finish) begin
                  seq_q <= sequence_sorted;
                  rank  <= trim_q;
               end else if (wait_cnt == WAIT_LAST) begin
                  err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WCW'(1);
               end
            end
            ST_ACCUM: begin
               if (idx_ok) begin
                  acc <= acc + SW'(pix_sel);
                  cnt <= cnt + (DW_sequence + 1)'(1);
               end
               rank <= rank + DW_sequence'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
